// File: rtl/cs_window_filter.sv
// Sliding-window CS filter: keeps the last WIN accepted samples and emits
// Y = (sum + WIN*Xappr) >> SHIFT two edges after each qualifying sample.
module cs_window_filter #(
  parameter int DW    = 8,
  parameter int WIN   = 9,
  parameter int SHIFT = 3,
  parameter int YW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] X,
  input  logic          mode,
  input  logic          flush,
  output logic          out_valid,
  output logic [YW-1:0] Y,
  output logic          win_full
);

  localparam int SW = DW + $clog2(WIN);
  localparam int CW = $clog2(WIN + 1);
  localparam logic [CW-1:0] LP_WIN    = CW'(WIN);
  localparam logic [CW-1:0] LP_WIN_M1 = CW'(WIN - 1);
  localparam logic [CW-1:0] LP_ONE    = CW'(1);
  localparam logic [SW-1:0] LP_WIN_S  = SW'(WIN);
  localparam logic [SW:0]   LP_WIN_T  = (SW+1)'(WIN);

  // Stage 1: window, running sum, fill count
  logic [DW-1:0] r_win [WIN];
  logic [SW-1:0] r_sum;
  logic [CW-1:0] r_count;
  logic          r_s1_valid;
  logic          r_s1_mode;

  // Stage 2: selected approximation captured with its sum
  logic          r_s2_valid;
  logic [SW-1:0] r_s2_sum;
  logic [DW-1:0] r_s2_xappr;

  logic [SW-1:0] w_x_ext;
  logic [SW-1:0] w_old_ext;
  logic [DW-1:0] w_xappr;
  logic          w_found;
  logic          w_qual;
  logic [SW-1:0] w_prod;
  logic [SW:0]   w_total;

  assign w_x_ext   = SW'(X);
  assign w_old_ext = SW'(r_win[WIN-1]);
  assign win_full  = (r_count == LP_WIN);

  // The sum wraps harmlessly in SW bits: X - oldest always lands in range.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIN; i++) r_win[i] <= '0;
      r_sum      <= '0;
      r_count    <= '0;
      r_s1_valid <= 1'b0;
      r_s1_mode  <= 1'b0;
    end else if (flush) begin
      for (int i = 1; i < WIN; i++) r_win[i] <= '0;
      r_win[0]   <= in_valid ? X : '0;
      r_sum      <= in_valid ? w_x_ext : '0;
      r_count    <= in_valid ? LP_ONE : '0;
      r_s1_valid <= 1'b0;
      r_s1_mode  <= mode;
    end else if (in_valid) begin
      for (int i = 1; i < WIN; i++) r_win[i] <= r_win[i-1];
      r_win[0]   <= X;
      r_sum      <= r_sum + w_x_ext - w_old_ext;
      if (r_count != LP_WIN) r_count <= r_count + LP_ONE;
      r_s1_valid <= (r_count >= LP_WIN_M1);
      r_s1_mode  <= mode;
    end else begin
      r_s1_valid <= 1'b0;
    end
  end

  // Divider-free average test: Xi*WIN compared against the sum directly.
  always_comb begin
    w_xappr = '0;
    w_found = 1'b0;
    w_qual  = 1'b0;
    w_prod  = '0;
    for (int i = 0; i < WIN; i++) begin
      w_prod = SW'(r_win[i]) * LP_WIN_S;
      w_qual = r_s1_mode ? (w_prod >= r_sum) : (w_prod <= r_sum);
      if (w_qual && (!w_found ||
          (r_s1_mode ? (r_win[i] < w_xappr) : (r_win[i] > w_xappr)))) begin
        w_xappr = r_win[i];
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_sum   <= '0;
      r_s2_xappr <= '0;
    end else if (flush) begin
      r_s2_valid <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_sum   <= r_sum;
        r_s2_xappr <= w_xappr;
      end
    end
  end

  assign w_total = {1'b0, r_s2_sum} + ((SW+1)'(r_s2_xappr) * LP_WIN_T);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      Y         <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= r_s2_valid;
      if (r_s2_valid) Y <= YW'(w_total >> SHIFT);
    end
  end

endmodule

// File: tb/tb_cs_window_filter.sv
// Directed bench for cs_window_filter at default parameters (DW=8, WIN=9,
// SHIFT=3, YW=10); expected values are worked out by hand from the filter formula.
module tb_cs_window_filter;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] X;
  logic       mode;
  logic       flush;
  logic       out_valid;
  logic [9:0] Y;
  logic       win_full;

  int n_checks = 0;
  int n_pass   = 0;

  cs_window_filter #(.DW(8), .WIN(9), .SHIFT(3), .YW(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .X        (X),
    .mode     (mode),
    .flush    (flush),
    .out_valid(out_valid),
    .Y        (Y),
    .win_full (win_full)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [7:0] x, input logic m);
    in_valid = 1'b1;
    X        = x;
    mode     = m;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; X = '0; mode = 1'b0; flush = 1'b0;
    repeat (2) step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_ov: got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (Y !== 10'h000) $display("FAIL reset_y: got %h exp 000", Y); else n_pass++;
    n_checks++; if (win_full !== 1'b0) $display("FAIL reset_wf: got %b exp 0", win_full); else n_pass++;
    #2 reset = 1'b0;
    step();
  endtask

  // 1..9: sum 45, Xappr 5, Y = 90>>3 = 11
  task automatic test_ramp();
    logic saw;
    saw = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      feed(8'(i), 1'b0);
      if (out_valid !== 1'b0) saw = 1'b1;
    end
    n_checks++; if (saw !== 1'b0) $display("FAIL ramp_early_ov: got %b exp 0", saw); else n_pass++;
    n_checks++; if (win_full !== 1'b0) $display("FAIL ramp_wf8: got %b exp 0", win_full); else n_pass++;
    feed(8'd9, 1'b0);
    n_checks++; if (win_full !== 1'b1) $display("FAIL ramp_wf9: got %b exp 1", win_full); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL ramp_ov_k: got %b exp 0", out_valid); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL ramp_ov_k1: got %b exp 0", out_valid); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b1) $display("FAIL ramp_ov_k2: got %b exp 1", out_valid); else n_pass++;
    n_checks++; if (Y !== 10'h00B) $display("FAIL ramp_y: got %h exp 00b", Y); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL ramp_ov_after: got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (Y !== 10'h00B) $display("FAIL ramp_y_hold: got %h exp 00b", Y); else n_pass++;
  endtask

  // Eight 0s then 10: sum 10; mode 0 -> 0, Y=1; mode 1 -> 10, Y=100>>3=12
  task automatic test_mode();
    do_flush();
    for (int i = 0; i < 8; i++) feed(8'd0, 1'b0);
    feed(8'd10, 1'b0);
    step(); step();
    n_checks++; if (out_valid !== 1'b1) $display("FAIL mode0_ov: got %b exp 1", out_valid); else n_pass++;
    n_checks++; if (Y !== 10'h001) $display("FAIL mode0_y: got %h exp 001", Y); else n_pass++;
    do_flush();
    for (int i = 0; i < 8; i++) feed(8'd0, 1'b1);
    feed(8'd10, 1'b1);
    step(); step();
    n_checks++; if (out_valid !== 1'b1) $display("FAIL mode1_ov: got %b exp 1", out_valid); else n_pass++;
    n_checks++; if (Y !== 10'h00C) $display("FAIL mode1_y: got %h exp 00c", Y); else n_pass++;
  endtask

  // Nine 0xFF: Y=4590>>3=0x23D. Then 0x00 (mode 1): sum 2040, Xappr 255, Y=4335>>3=0x21D.
  // Then 0x00 (mode 0): sum 1785, Xappr 0, Y=1785>>3=0x0DF.
  task automatic test_back_to_back();
    do_flush();
    for (int i = 0; i < 9; i++) feed(8'hFF, 1'b0);
    feed(8'h00, 1'b1);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL b2b_ov_k1: got %b exp 0", out_valid); else n_pass++;
    feed(8'h00, 1'b0);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL b2b_ov_a: got %b exp 1", out_valid); else n_pass++;
    n_checks++; if (Y !== 10'h23D) $display("FAIL b2b_full_scale: got %h exp 23d", Y); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b1) $display("FAIL b2b_ov_b: got %b exp 1", out_valid); else n_pass++;
    n_checks++; if (Y !== 10'h21D) $display("FAIL b2b_y_mode1: got %h exp 21d", Y); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b1) $display("FAIL b2b_ov_c: got %b exp 1", out_valid); else n_pass++;
    n_checks++; if (Y !== 10'h0DF) $display("FAIL b2b_y_mode0: got %h exp 0df", Y); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL b2b_ov_end: got %b exp 0", out_valid); else n_pass++;
  endtask

  // 1..10 then a 3-cycle gap then 11: outputs 11 (1..9), 13 (2..10), 15 (3..11)
  task automatic test_gap();
    do_flush();
    for (int i = 1; i <= 9; i++) feed(8'(i), 1'b0);
    feed(8'd10, 1'b0);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL gap_ov_pre: got %b exp 0", out_valid); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b1 || Y !== 10'h00B) $display("FAIL gap_drain1: got ov=%b y=%h exp ov=1 y=00b", out_valid, Y); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b1 || Y !== 10'h00D) $display("FAIL gap_drain2: got ov=%b y=%h exp ov=1 y=00d", out_valid, Y); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b0 || Y !== 10'h00D) $display("FAIL gap_hold: got ov=%b y=%h exp ov=0 y=00d", out_valid, Y); else n_pass++;
    feed(8'd11, 1'b0);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL gap_ov_a: got %b exp 0", out_valid); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL gap_ov_b: got %b exp 0", out_valid); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b1 || Y !== 10'h00F) $display("FAIL gap_after: got ov=%b y=%h exp ov=1 y=00f", out_valid, Y); else n_pass++;
  endtask

  // Flush with a sample in flight; 20..28 refill: sum 216, Y=432>>3=54
  task automatic test_flush();
    feed(8'd12, 1'b0);
    flush = 1'b1; in_valid = 1'b1; X = 8'd20; mode = 1'b0;
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_ov: got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (win_full !== 1'b0) $display("FAIL flush_wf: got %b exp 0", win_full); else n_pass++;
    n_checks++; if (Y !== 10'h00F) $display("FAIL flush_y_hold: got %h exp 00f", Y); else n_pass++;
    for (int i = 21; i <= 28; i++) begin
      feed(8'(i), 1'b0);
      n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_ov_refill: sample %0d got %b exp 0", i, out_valid); else n_pass++;
      n_checks++; if (win_full !== (i == 28)) $display("FAIL flush_wf_refill: sample %0d got %b exp %b", i, win_full, (i == 28)); else n_pass++;
    end
    step(); step();
    n_checks++; if (out_valid !== 1'b1 || Y !== 10'd54) $display("FAIL flush_first_out: got ov=%b y=%0d exp ov=1 y=54", out_valid, Y); else n_pass++;
  endtask

  // Reset off the edge with samples in flight; refill with nine 7s -> Y=126>>3=15
  task automatic test_reset_mid();
    logic saw;
    feed(8'd30, 1'b0);
    feed(8'd31, 1'b0);
    #2 reset = 1'b1;
    #1;
    n_checks++; if (Y !== 10'h000) $display("FAIL rst_mid_y: got %h exp 000", Y); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_mid_ov: got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (win_full !== 1'b0) $display("FAIL rst_mid_wf: got %b exp 0", win_full); else n_pass++;
    step(); step();
    #2 reset = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_stale_a: got %b exp 0", out_valid); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_stale_b: got %b exp 0", out_valid); else n_pass++;
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      feed(8'd7, 1'b0);
      if (out_valid !== 1'b0) saw = 1'b1;
    end
    n_checks++; if (saw !== 1'b0) $display("FAIL rst_refill_ov: got %b exp 0", saw); else n_pass++;
    n_checks++; if (win_full !== 1'b0) $display("FAIL rst_refill_wf8: got %b exp 0", win_full); else n_pass++;
    feed(8'd7, 1'b0);
    n_checks++; if (win_full !== 1'b1) $display("FAIL rst_refill_wf9: got %b exp 1", win_full); else n_pass++;
    step(); step();
    n_checks++; if (out_valid !== 1'b1 || Y !== 10'h00F) $display("FAIL rst_refill_out: got ov=%b y=%h exp ov=1 y=00f", out_valid, Y); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_mode();
    test_back_to_back();
    test_gap();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
